// File: rtl/conv_rdreq_sched_pkg.sv
// Shared types and field layout for the convolution read-request scheduler.
package conv_rdreq_sched_pkg;

    localparam int DIM_WIDTH_DEF = 8;
    localparam int W_LSB = 0;
    localparam int H_LSB = 8;
    localparam int K_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LINE = 3'd2,
        ST_EOL  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Rejects an empty line, an empty kernel, or a kernel taller than the map.
    function automatic logic cfg_invalid(input logic [DIM_WIDTH_DEF-1:0] w,
                                         input logic [DIM_WIDTH_DEF-1:0] h,
                                         input logic [DIM_WIDTH_DEF-1:0] k);
        return (k == {DIM_WIDTH_DEF{1'b0}}) || (w == {DIM_WIDTH_DEF{1'b0}}) || (k > h);
    endfunction

endpackage

// File: rtl/conv_rdreq_sched_if.sv
// Handshake between the scheduler (master) and the per-line request generator (slave).
interface conv_rdreq_sched_if;
    logic fifo_afull;
    logic req;
    logic stall;
    logic eol;

    modport master (input fifo_afull, output req, output stall, output eol);
    modport slave  (output fifo_afull, input req, input stall, input eol);
endinterface

// File: rtl/conv_rdreq_sched_cnt.sv
// Nested beat/line/row counter with terminal-count flags for the scheduler FSM.
module conv_rdreq_cnt #(
    parameter int DIM_WIDTH         = 8,
    parameter int KERNEL_SIZE_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         beat_inc,
    input  logic                         eol,
    input  logic [DIM_WIDTH-1:0]         w,
    input  logic [DIM_WIDTH-1:0]         rows_total,
    input  logic [KERNEL_SIZE_WIDTH-1:0] k,
    output logic                         beat_last,
    output logic                         line_last,
    output logic                         row_last,
    output logic [DIM_WIDTH-1:0]         row_cnt
);

    logic [DIM_WIDTH-1:0]         beat_q, beat_d;
    logic [KERNEL_SIZE_WIDTH-1:0] line_q, line_d;
    logic [DIM_WIDTH-1:0]         row_q, row_d;

    // Terminal compares use W-1 so W=255 never needs a wider counter.
    assign beat_last = (beat_q == (w - DIM_WIDTH'(1'b1)));
    assign line_last = (line_q == (k - KERNEL_SIZE_WIDTH'(1'b1)));
    assign row_last  = (row_q == (rows_total - DIM_WIDTH'(1'b1)));
    assign row_cnt   = row_q;

    // Next-count logic: EOL rolls the line/row indices, accepted beats advance the beat index.
    always_comb begin
        beat_d = beat_q;
        line_d = line_q;
        row_d  = row_q;
        if (clr) begin
            beat_d = {DIM_WIDTH{1'b0}};
            line_d = {KERNEL_SIZE_WIDTH{1'b0}};
            row_d  = {DIM_WIDTH{1'b0}};
        end else if (eol) begin
            beat_d = {DIM_WIDTH{1'b0}};
            if (line_last) begin
                line_d = {KERNEL_SIZE_WIDTH{1'b0}};
                if (!row_last) begin
                    row_d = row_q + DIM_WIDTH'(1'b1);
                end else begin
                    row_d = row_q;
                end
            end else begin
                line_d = line_q + KERNEL_SIZE_WIDTH'(1'b1);
            end
        end else if (beat_inc) begin
            beat_d = beat_q + DIM_WIDTH'(1'b1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= {DIM_WIDTH{1'b0}};
            line_q <= {KERNEL_SIZE_WIDTH{1'b0}};
            row_q  <= {DIM_WIDTH{1'b0}};
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
            row_q  <= row_d;
        end
    end

endmodule

// File: rtl/conv_rdreq_sched.sv
// Scheduler walking a KxK window down the input map, one W-beat line request at a time.
// Optional stall-cycle counter port enabled by defining CONV_RDREQ_PERF_EN.
module conv_rdreq_sched
    import conv_rdreq_sched_pkg::*;
#(
    parameter int REG_WIDTH         = 32,
    parameter int KERNEL_SIZE_WIDTH = 2,
    parameter int DIM_WIDTH         = DIM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [REG_WIDTH-1:0]  i_conf_inputshape,
    input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
    conv_rdreq_sched_if.master    gen,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
`ifdef CONV_RDREQ_PERF_EN
    output logic [31:0]           o_stall_cycles,
`endif
    output logic [DIM_WIDTH-1:0]  o_row_cnt
);

    state_e state_q, state_d;

    logic [DIM_WIDTH-1:0]         cfg_w_s, cfg_h_s;
    logic [KERNEL_SIZE_WIDTH-1:0] cfg_k_s;
    logic                         cfg_err_s;
    logic [DIM_WIDTH-1:0]         w_q, w_d, rows_total_q, rows_total_d;
    logic [KERNEL_SIZE_WIDTH-1:0] k_q, k_d;
    logic                         err_q, err_d;
    logic                         accept_s, beat_last_s, line_last_s, row_last_s;
    logic                         req_s, stall_s, eol_s, busy_s, done_s;
    logic                         unused_cfg_s;

    assign cfg_w_s   = i_conf_inputshape[W_LSB +: DIM_WIDTH];
    assign cfg_h_s   = i_conf_inputshape[H_LSB +: DIM_WIDTH];
    assign cfg_k_s   = i_conf_kernelshape[K_LSB +: KERNEL_SIZE_WIDTH];
    assign cfg_err_s = cfg_invalid(DIM_WIDTH_DEF'(cfg_w_s), DIM_WIDTH_DEF'(cfg_h_s),
                                   DIM_WIDTH_DEF'(cfg_k_s));
    assign unused_cfg_s = ^{i_conf_inputshape[REG_WIDTH-1:H_LSB+DIM_WIDTH],
                            i_conf_kernelshape[REG_WIDTH-1:K_LSB+KERNEL_SIZE_WIDTH]};
    assign accept_s  = req_s && !stall_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = i_start ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = cfg_err_s ? ST_DONE : ST_LINE;
            ST_LINE: state_d = (accept_s && beat_last_s) ? ST_EOL : ST_LINE;
            ST_EOL:  state_d = (line_last_s && row_last_s) ? ST_DONE : ST_LINE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; stall follows the FIFO combinationally only while requesting.
    always_comb begin
        req_s   = 1'b0;
        stall_s = 1'b0;
        eol_s   = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            ST_LOAD: busy_s = 1'b1;
            ST_LINE: begin
                req_s   = 1'b1;
                stall_s = gen.fifo_afull;
                busy_s  = 1'b1;
            end
            ST_EOL: begin
                eol_s  = 1'b1;
                busy_s = 1'b1;
            end
            ST_DONE: done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Shadow config and sticky error; the pass only ever sees values captured in LOAD.
    always_comb begin
        w_d          = w_q;
        k_d          = k_q;
        rows_total_d = rows_total_q;
        err_d        = err_q;
        if ((state_q == ST_IDLE) && i_start) begin
            err_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            w_d          = cfg_w_s;
            k_d          = cfg_k_s;
            rows_total_d = cfg_h_s - DIM_WIDTH'(cfg_k_s) + DIM_WIDTH'(1'b1);
            err_d        = cfg_err_s;
        end else begin
            err_d = err_q;
        end
    end

    // Shadow config and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_q          <= {DIM_WIDTH{1'b0}};
            k_q          <= {KERNEL_SIZE_WIDTH{1'b0}};
            rows_total_q <= {DIM_WIDTH{1'b0}};
            err_q        <= 1'b0;
        end else begin
            w_q          <= w_d;
            k_q          <= k_d;
            rows_total_q <= rows_total_d;
            err_q        <= err_d;
        end
    end

    conv_rdreq_cnt #(
        .DIM_WIDTH         (DIM_WIDTH),
        .KERNEL_SIZE_WIDTH (KERNEL_SIZE_WIDTH)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q == ST_LOAD),
        .beat_inc   (accept_s),
        .eol        (eol_s),
        .w          (w_q),
        .rows_total (rows_total_q),
        .k          (k_q),
        .beat_last  (beat_last_s),
        .line_last  (line_last_s),
        .row_last   (row_last_s),
        .row_cnt    (o_row_cnt)
    );

`ifdef CONV_RDREQ_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of requesting cycles lost to back-pressure.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (state_q == ST_LOAD) begin
            stall_cycles_d = 32'd0;
        end else if (req_s && stall_s && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
`endif

    assign gen.req   = req_s;
    assign gen.stall = stall_s;
    assign gen.eol   = eol_s;
    assign o_busy    = busy_s;
    assign o_done    = done_s;
    assign o_err     = err_q;

endmodule
